instruction_queue_reg: RTL

Parametrised successor to the CPU's single instruction register. It holds a DEPTH-entry queue of fetched instruction words, so fetch can run ahead of decode. The head word is split into opcode and address fields for the decoder. Sits between the memory fetch path and the controller, with valid/ready handshakes on both sides and a synchronous flush for jumps.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ir_queue_mem.sv | 29 ++
 rtl/instruction_queue_reg.sv | 77 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU instruction-word widths, opcode encoding and reset constant
package cpu_pkg;

    localparam int CPU_OPCODE_W = 3;
    localparam int CPU_ADDR_W   = 5;
    localparam int CPU_INSTR_W  = CPU_OPCODE_W + CPU_ADDR_W;

    typedef enum logic [CPU_OPCODE_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    localparam logic [CPU_INSTR_W-1:0] INSTR_RESET = '0;

endpackage

// File: rtl/ir_queue_mem.sv
// ir_queue_mem: DEPTH x W register array, one write port, async read port, async clear
module ir_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // storage: cleared on reset, written one entry per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue_reg.sv
// instruction_queue_reg: DEPTH-entry instruction queue with opcode/address split at the head.
// Optional zero-latency empty-queue bypass enabled by defining IR_BYPASS_EN.
module instruction_queue_reg
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = CPU_OPCODE_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DEPTH    = 4,
    localparam int INSTR_W = OPCODE_W + ADDR_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   address,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [INSTR_W-1:0] rdata, head;
    logic               empty, full, push, pop, bypass, we;

    assign empty    = count == '0;
    assign full     = count == CNT_W'(DEPTH);
    assign in_ready = rst_n && !full && !flush;
    assign push     = in_valid && in_ready;

`ifdef IR_BYPASS_EN
    assign bypass = rst_n && empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign pop       = !empty && out_ready;
    // a bypassed word consumed in the same cycle never enters storage
    assign we        = push && !(bypass && out_ready);

    ir_queue_mem #(.DEPTH(DEPTH), .W(INSTR_W)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // pointers and occupancy; flush overrides any handshake in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (we)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(we) - CNT_W'(pop);
        end
    end

    assign head    = !out_valid ? INSTR_W'(INSTR_RESET) : bypass ? in_data : rdata;
    assign opcode  = head[INSTR_W-1:ADDR_W];
    assign address = head[ADDR_W-1:0];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule
